// File: rtl/reference_buffer_stream.sv
// Streams packed I/Q ROM samples in bursts of up to 2**len_bits-1 beats per accepted command.
// Latency: first sample valid 2 cycles after command accept, then up to 1 sample/clk.
// Backpressure: output register + 1-entry skid; ROM reads pause only while the skid is full.
module reference_buffer_stream #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int len_bits      = 5,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  // ROM image fixed at elaboration: entry k lives in bits [k*word+:word], I in the upper field
  parameter logic [buffer_length*(i_bits+q_bits)-1:0] rom_init = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_axi_cvalid,
  input  logic [index_bits-1:0]     m_axi_caddr,
  input  logic [len_bits-1:0]       m_axi_clen,
  input  logic                      m_axi_cwrap,
  output logic                      s_axi_cready,
  input  logic                      m_axi_rready,
  output logic                      s_axi_rvalid,
  output logic signed [i_bits-1:0]  i,
  output logic signed [q_bits-1:0]  q,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rerr,
  output logic                      busy
);

  localparam int word_bits = i_bits + q_bits;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, ERR} state_t;

  typedef struct packed {
    logic [word_bits-1:0] word;
    logic                 last;
    logic                 err;
  } beat_t;

  // ROM padded to the full address space so any index is in range
  logic [word_bits-1:0] rom [2**index_bits];

  for (genvar g = 0; g < 2**index_bits; g++) begin : g_rom
    if (g < buffer_length) begin : g_used
      assign rom[g] = rom_init[g*word_bits +: word_bits];
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  state_t                state_q, state_d;
  logic [index_bits-1:0] addr_q, addr_d;
  logic [len_bits-1:0]   rem_q, rem_d;
  logic                  trunc_q, trunc_d;

  logic  rd_vld_q, rd_vld_d, out_vld_q, out_vld_d, sk_vld_q, sk_vld_d;
  beat_t rd_q, rd_d, out_q, out_d, sk_q, sk_d;

  logic                  cmd_accept, cmd_bad, cmd_trunc;
  logic [len_bits-1:0]   cmd_total;
  logic                  pop, rd_take, rd_free;
  logic                  issue, issue_last, issue_err;
  logic [index_bits-1:0] issue_addr;

  function automatic logic [index_bits-1:0] next_addr(input logic [index_bits-1:0] a);
    if (int'(a) == buffer_length - 1) return '0;
    return a + index_bits'(1);
  endfunction

  assign s_axi_cready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign cmd_accept   = m_axi_cvalid && s_axi_cready;

  assign pop     = out_vld_q && m_axi_rready;
  // the read register can hand over unless both output slots stay occupied
  assign rd_take = rd_vld_q && (!sk_vld_q || pop);
  assign rd_free = !rd_vld_q || rd_take;

  // Decode the presented command: validity, truncation at the buffer end, beat count
  always_comb begin
    cmd_bad   = (int'(m_axi_caddr) >= buffer_length) || (m_axi_clen == '0);
    cmd_trunc = !m_axi_cwrap && (int'(m_axi_clen) > buffer_length - int'(m_axi_caddr));
    cmd_total = cmd_trunc ? len_bits'(buffer_length - int'(m_axi_caddr)) : m_axi_clen;
  end

  // Next-state and ROM read issue; the first read goes out in the accept cycle itself
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    trunc_d    = trunc_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    issue_last = 1'b0;
    issue_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          if (cmd_bad) begin
            state_d = ERR;
          end else begin
            issue      = 1'b1;
            issue_addr = m_axi_caddr;
            issue_last = (cmd_total == len_bits'(1));
            issue_err  = issue_last && cmd_trunc;
            addr_d     = next_addr(m_axi_caddr);
            rem_d      = cmd_total - len_bits'(1);
            trunc_d    = cmd_trunc;
            state_d    = STREAM;
          end
        end
      end
      STREAM: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (rd_free) begin
          issue      = 1'b1;
          issue_last = (rem_q == len_bits'(1));
          issue_err  = issue_last && trunc_q;
          addr_d     = next_addr(addr_q);
          rem_d      = rem_q - len_bits'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_q.last) state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read register -> output register / skid movement, oldest beat always in the output register
  always_comb begin
    rd_vld_d  = rd_vld_q && !rd_take;
    rd_d      = rd_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    sk_vld_d  = sk_vld_q;
    sk_d      = sk_q;
    if (issue) begin
      rd_vld_d  = 1'b1;
      rd_d.word = rom[issue_addr];
      rd_d.last = issue_last;
      rd_d.err  = issue_err;
    end
    if (pop) begin
      if (sk_vld_q) begin
        out_d    = sk_q;
        sk_vld_d = rd_take;
        if (rd_take) sk_d = rd_q;
      end else begin
        out_vld_d = rd_take;
        if (rd_take) out_d = rd_q;
      end
    end else if (!out_vld_q) begin
      out_vld_d = rd_take;
      if (rd_take) out_d = rd_q;
    end else if (rd_take) begin
      sk_vld_d = 1'b1;
      sk_d     = rd_q;
    end
  end

  // State and pipeline registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      trunc_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_q      <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      sk_vld_q  <= 1'b0;
      sk_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      trunc_q   <= trunc_d;
      rd_vld_q  <= rd_vld_d;
      rd_q      <= rd_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      sk_vld_q  <= sk_vld_d;
      sk_q      <= sk_d;
    end
  end

  assign s_axi_rvalid = out_vld_q;
  assign i            = out_q.word[word_bits-1:q_bits];
  assign q            = out_q.word[q_bits-1:0];
  assign s_axi_rlast  = out_vld_q && out_q.last;
  assign s_axi_rerr   = (state_q == ERR) || (out_vld_q && out_q.err);

endmodule

// File: tb/tb_reference_buffer_stream.sv
// Bench for reference_buffer_stream: directed and random bursts checked against a beat-list model.
module tb_reference_buffer_stream;

  localparam int BL = 10;
  localparam int IB = 4;
  localparam int LB = 5;
  localparam int W  = 12;

  function automatic logic [BL*2*W-1:0] mk_rom();
    logic [BL*2*W-1:0] r;
    r = '0;
    for (int k = 0; k < BL; k++) r[k*2*W +: 2*W] = {12'(k), 12'(-k)};
    return r;
  endfunction

  localparam logic [BL*2*W-1:0] ROM_IMG = mk_rom();

  typedef struct {
    logic [W-1:0] ei;
    logic [W-1:0] eq;
    logic         last;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cvalid = 1'b0;
  logic [IB-1:0] caddr = '0;
  logic [LB-1:0] clen = '0;
  logic          cwrap = 1'b0;
  logic          rready = 1'b0;
  logic          cready, rvalid, rlast, rerr, busy;
  logic [W-1:0]  i_o, q_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reference_buffer_stream #(
    .buffer_length(BL), .index_bits(IB), .len_bits(LB), .i_bits(W), .q_bits(W),
    .rom_init(ROM_IMG)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axi_cvalid(cvalid), .m_axi_caddr(caddr), .m_axi_clen(clen), .m_axi_cwrap(cwrap),
    .s_axi_cready(cready), .m_axi_rready(rready), .s_axi_rvalid(rvalid),
    .i(i_o), .q(q_o), .s_axi_rlast(rlast), .s_axi_rerr(rerr), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cready"}, 32'(cready), 1);
    check({tag, "_rvalid"}, 32'(rvalid), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_rerr"},   32'(rerr), 0);
    check({tag, "_rlast"},  32'(rlast), 0);
    check({tag, "_i"},      32'(i_o), 0);
    check({tag, "_q"},      32'(q_o), 0);
  endtask

  // One command from issue to idle; abort_after>0 applies reset after that many beats
  task automatic run_burst(input int addr, input int len, input bit wrap,
                           input bit rnd_rdy, input int abort_after);
    exp_t         expq[$];
    exp_t         e;
    int           n, t, cyc, got, a;
    bit           trunc, bad, seen, prev_stall;
    logic [W-1:0] pi, pq;
    logic         pl;

    bad = (addr >= BL) || (len == 0);
    if (!bad) begin
      n = len;
      trunc = 1'b0;
      if (!wrap && len > BL - addr) begin
        n = BL - addr;
        trunc = 1'b1;
      end
      for (int j = 0; j < n; j++) begin
        a = (addr + j) % BL;
        e.ei = 12'(a);
        e.eq = 12'(-a);
        e.last = (j == n - 1);
        e.err = (j == n - 1) && trunc;
        expq.push_back(e);
      end
    end

    @(negedge clk);
    cvalid = 1'b1;
    caddr = IB'(addr);
    clen = LB'(len);
    cwrap = wrap;
    rready = 1'b0;
    t = 0;
    while (!cready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_cready", 32'(cready), 1);

    @(negedge clk);
    check("post_accept_cready", 32'(cready), 0);
    check("post_accept_busy", 32'(busy), 1);
    check("post_accept_rvalid", 32'(rvalid), 0);
    // a competing command held while busy must be ignored
    caddr = IB'($urandom_range(0, BL - 1));
    clen = LB'($urandom_range(1, 3));
    cwrap = 1'($urandom);
    cvalid = 1'b1;

    if (bad) begin
      check("err_pulse", 32'(rerr), 1);
      @(negedge clk);
      cvalid = 1'b0;
      check("err_done_rerr", 32'(rerr), 0);
      check("err_done_cready", 32'(cready), 1);
      check("err_done_busy", 32'(busy), 0);
      check("err_no_rvalid", 32'(rvalid), 0);
      return;
    end
    check("no_early_rerr", 32'(rerr), 0);

    cyc = 1;
    seen = 1'b0;
    prev_stall = 1'b0;
    got = 0;
    pi = '0;
    pq = '0;
    pl = 1'b0;
    while (expq.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (abort_after > 0 && got == abort_after) begin
        rst = 1'b1;
        cvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        return;
      end
      if (!seen && rvalid) begin
        seen = 1'b1;
        check("first_beat_latency", 32'(cyc), 2);
      end
      if (!rnd_rdy && seen) check("no_bubble", 32'(rvalid), 1);
      if (prev_stall) begin
        check("hold_rvalid", 32'(rvalid), 1);
        check("hold_i", 32'(i_o), 32'(pi));
        check("hold_q", 32'(q_o), 32'(pq));
        check("hold_rlast", 32'(rlast), 32'(pl));
      end
      rready = rnd_rdy ? 1'($urandom) : 1'b1;
      if (rvalid && rready) begin
        e = expq.pop_front();
        check("beat_i", 32'(i_o), 32'(e.ei));
        check("beat_q", 32'(q_o), 32'(e.eq));
        check("beat_rlast", 32'(rlast), 32'(e.last));
        check("beat_rerr", 32'(rerr), 32'(e.err));
        got++;
      end else if (!rvalid) begin
        check("idle_rerr", 32'(rerr), 0);
      end
      prev_stall = rvalid && !rready;
      pi = i_o;
      pq = q_o;
      pl = rlast;
    end
    check("burst_complete", 32'(expq.size()), 0);

    @(negedge clk);
    cvalid = 1'b0;
    rready = 1'b0;
    check("end_busy", 32'(busy), 0);
    check("end_cready", 32'(cready), 1);
    check("end_rvalid", 32'(rvalid), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    run_burst(2, 4, 1'b0, 1'b0, 0);    // linear
    run_burst(8, 5, 1'b1, 1'b0, 0);    // wrap
    run_burst(8, 5, 1'b0, 1'b0, 0);    // truncate
    run_burst(0, 10, 1'b0, 1'b1, 0);   // backpressure
    run_burst(12, 3, 1'b0, 1'b0, 0);   // bad address
    run_burst(3, 0, 1'b1, 1'b0, 0);    // zero length
    run_burst(0, 10, 1'b0, 1'b0, 3);   // reset mid-burst
    run_burst(1, 3, 1'b0, 1'b0, 0);    // accepted normally after abort
    run_burst(5, 1, 1'b0, 1'b0, 0);    // single beat
    run_burst(9, 1, 1'b0, 1'b1, 0);    // single beat at the end
    run_burst(9, 2, 1'b0, 1'b1, 0);    // truncated to one beat
    run_burst(0, 31, 1'b1, 1'b1, 0);   // maximum length with wrap

    for (int r = 0; r < 25; r++) begin
      run_burst(int'($urandom_range(0, 11)), int'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
